// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: FSM state encoding and
// the default byte width.
package uart_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/tx_fifo_feeder_if.sv
// Producer / transmitter handshake bundle for tx_fifo_feeder.
// master = producer and UART side (testbench), slave = the feeder.
interface tx_fifo_feeder_if
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = 4
) ();

    logic                  wr_en;
    logic [DATA_W-1:0]     wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  tx_start;
    logic [DATA_W-1:0]     tx_din;
    logic                  tx_done_tick;
    logic                  busy;

    modport master (
        output wr_en, wr_data, tx_done_tick,
        input  full, empty, count, tx_start, tx_din, busy
    );

    modport slave (
        input  wr_en, wr_data, tx_done_tick,
        output full, empty, count, tx_start, tx_din, busy
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage array, wrapping read/write pointers and
// registered occupancy flags. Writes into a full FIFO and reads from an
// empty FIFO are ignored. rd_data always shows the head entry.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_acc = wr_en && !full_q;
    assign rd_acc = rd_en && !empty_q;

    // Next pointers and occupancy; pointer width makes the wrap implicit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    // Control state, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/tx_fifo_feeder.sv
// Buffers producer bytes in a FIFO and hands them one at a time to a UART
// transmitter: pop into tx_din, pulse tx_start, wait for tx_done_tick.
// Optional sticky overflow flag (ovf/ovf_clr) enabled by TX_FIFO_OVF_FLAG_EN.
module tx_fifo_feeder
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    tx_fifo_feeder_if.slave bus
`ifdef TX_FIFO_OVF_FLAG_EN
    ,
    output logic            ovf,
    input  logic            ovf_clr
`endif
);

    logic [DATA_W-1:0]   fifo_rd_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                pop;

    logic [1:0]          state_q, state_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_din_q, tx_din_d;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Handshake FSM: the pop happens on the IDLE->LOAD edge, and tx_start is
    // registered so it is high during the first cycle of WAIT_DONE.
    always_comb begin
        state_d  = state_q;
        tx_din_d = tx_din_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    tx_din_d = fifo_rd_data;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        tx_start_d = (state_q == ST_LOAD);
    end

    // FSM and transmitter-facing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_din_q   <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_din_q   <= tx_din_d;
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_din   = tx_din_q;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_count;
    assign bus.busy     = (state_q != ST_IDLE) || !fifo_empty;

`ifdef TX_FIFO_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: a dropped write wins over a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (bus.wr_en && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// Testbench for tx_fifo_feeder: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model and a byte
// scoreboard of accepted writes.
module tb_tx_fifo_feeder;

    localparam int DW    = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    localparam int P_FREE  = 0;
    localparam int P_START = 1;
    localparam int P_WAIT  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tx_fifo_feeder_if #(.DATA_W(DW), .DEPTH_LOG2(DL)) bus ();

`ifdef TX_FIFO_OVF_FLAG_EN
    logic ovf;
    logic ovf_clr = 1'b0;
    logic m_ovf   = 1'b0;
`endif

    tx_fifo_feeder #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef TX_FIFO_OVF_FLAG_EN
        ,
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`endif
    );

    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] m_q[$];
    logic [7:0] acc_q[$];
    int         m_phase = P_FREE;
    logic       m_start = 1'b0;
    logic [7:0] m_din   = 8'h00;
    int         n_sent  = 0;

    bit         auto_uart = 1'b1;
    int         uart_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("count", 32'(bus.count), 32'(m_q.size()));
        chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
        chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
        chk("tx_start", 32'(bus.tx_start), 32'(m_start));
        chk("tx_din", 32'(bus.tx_din), 32'(m_din));
        chk("busy", 32'(bus.busy), 32'((m_phase != P_FREE) || (m_q.size() != 0)));
`ifdef TX_FIFO_OVF_FLAG_EN
        chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    endtask

    task automatic model_clear();
        m_q.delete();
        acc_q.delete();
        m_phase  = P_FREE;
        m_start  = 1'b0;
        m_din    = 8'h00;
        uart_cnt = 0;
`ifdef TX_FIFO_OVF_FLAG_EN
        m_ovf = 1'b0;
`endif
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare.
    task automatic step(input logic we, input logic [7:0] d, input logic extra_done);
        logic done;
        logic full_m;
        logic acc;
        logic pop;
        done = extra_done;
        if (auto_uart && uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) done = 1'b1;
        end
        bus.wr_en        = we;
        bus.wr_data      = d;
        bus.tx_done_tick = done;
        @(posedge clk);
        full_m  = (m_q.size() == DEPTH);
        acc     = we && !full_m;
        pop     = (m_phase == P_FREE) && (m_q.size() != 0);
        m_start = (m_phase == P_START);
        if (m_phase == P_FREE) begin
            if (pop) m_phase = P_START;
        end else if (m_phase == P_START) begin
            m_phase = P_WAIT;
        end else if (done) begin
            m_phase = P_FREE;
        end
        if (pop) m_din = m_q.pop_front();
        if (acc) begin
            m_q.push_back(d);
            acc_q.push_back(d);
        end
`ifdef TX_FIFO_OVF_FLAG_EN
        if (we && full_m) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
`endif
        #1;
        check_outputs();
        if (bus.tx_start === 1'b1) begin
            if (acc_q.size() == 0) begin
                chk("sb_unexpected_start", 32'd1, 32'd0);
            end else begin
                chk("sb_byte", 32'(bus.tx_din), 32'(acc_q.pop_front()));
            end
            n_sent++;
            uart_cnt = $urandom_range(1, 6);
        end
        bus.wr_en        = 1'b0;
        bus.tx_done_tick = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n            = 1'b0;
        bus.wr_en        = 1'b0;
        bus.tx_done_tick = 1'b0;
        model_clear();
        #1;
        check_outputs();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        auto_uart = 1'b1;
        while ((m_q.size() != 0 || m_phase != P_FREE) && n < budget) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int sent_wr;
        bus.wr_en        = 1'b0;
        bus.wr_data      = 8'h00;
        bus.tx_done_tick = 1'b0;

        // Reset state while rst_n is low
        @(posedge clk);
        #1;
        check_outputs();
        chk("init_empty", 32'(bus.empty), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Single byte 0xA5 and start latency
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("lat_n1_no_start", 32'(bus.tx_start), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("lat_n2_start", 32'(bus.tx_start), 32'd1);
        chk("a5_din", 32'(bus.tx_din), 32'hA5);
        drain(50, "a5_done_busy");
        chk("a5_done_empty", 32'(bus.empty), 32'd1);

        // Three consecutive writes transmitted in order
        base = n_sent;
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        drain(100, "three_busy");
        chk("three_sent", 32'(n_sent - base), 32'd3);

        // Fill with transmitter stalled, then overflow writes
        auto_uart = 1'b0;
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        step(1'b1, 8'hFF, 1'b0);
        chk("ovf_write_count", 32'(bus.count), 32'd16);

        // Pop from full FIFO with a simultaneous (dropped) write
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hEE, 1'b0);
        chk("pop_drop_count", 32'(bus.count), 32'd15);
        chk("pop_drop_full", 32'(bus.full), 32'd0);

`ifdef TX_FIFO_OVF_FLAG_EN
        // Overflow flag clear, then clear coinciding with a dropped write
        chk("ovf_set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        step(1'b1, 8'hEE, 1'b0);
        ovf_clr = 1'b1;
        step(1'b1, 8'hFF, 1'b0);
        ovf_clr = 1'b0;
        chk("ovf_clr_vs_drop", 32'(ovf), 32'd1);
`endif
        drain(400, "full_drain_busy");

        // Reset in WAIT_DONE with 5 bytes queued, then a stray done tick
        auto_uart = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'd5);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        do_reset();
        auto_uart = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);
        chk("post_rst_no_start", 32'(bus.tx_start), 32'd0);

        // 20 sequential bytes through the 16-deep FIFO
        base    = n_sent;
        sent_wr = 0;
        for (int n = 0; n < 400 && sent_wr < 20; n++) begin
            if (m_q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
                step(1'b1, 8'(8'h40 + sent_wr), 1'b0);
                sent_wr++;
            end else begin
                step(1'b0, 8'h00, 1'b0);
            end
        end
        drain(300, "wrap_busy");
        chk("wrap_sent", 32'(n_sent - base), 32'd20);

        // Randomized traffic with stray done ticks outside WAIT_DONE
        for (int n = 0; n < 500; n++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'((m_phase != P_WAIT) && ($urandom_range(0, 7) == 0)));
        end
        drain(400, "rand_busy");
        chk("rand_sb_empty", 32'(acc_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
